// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared state encoding for the serial sequence generator and
//               the detector bench.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam logic [1:0] SEQ_IDLE  = 2'd0;
    localparam logic [1:0] SEQ_SHIFT = 2'd1;
    localparam logic [1:0] SEQ_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = SEQ_IDLE,
        ST_SHIFT = SEQ_SHIFT,
        ST_DONE  = SEQ_DONE
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/sequence_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : sequence_generator_if
// Description : Request/serial-stream bundle of the sequence generator.
//               SEQ_GEN_REPEAT_EN adds the repeat_en request signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface sequence_generator_if #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 6
);
    import seq_pkg::*;

    logic             start;
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] len;
`ifdef SEQ_GEN_REPEAT_EN
    logic             repeat_en;
`endif
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;
    seq_state_t       state;

    modport master (
        output start, data, len,
`ifdef SEQ_GEN_REPEAT_EN
        output repeat_en,
`endif
        input  out, out_valid, busy, done, state
    );

    modport slave (
        input  start, data, len,
`ifdef SEQ_GEN_REPEAT_EN
        input  repeat_en,
`endif
        output out, out_valid, busy, done, state
    );

endinterface
`default_nettype wire

// File: rtl/seq_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_reg
// Description : Left-aligning load/shift register; bit ld_len-1 of ld_data is
//               placed at the MSB, which is the serial output.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_reg #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [LEN_W-1:0] ld_len,
    output logic             msb
);
    localparam logic [LEN_W-1:0] c_WIDTH_L = LEN_W'(WIDTH);

    logic [WIDTH-1:0] r_sr;
    logic [LEN_W-1:0] w_shamt;

    // ld_len is already clamped to 1..WIDTH, so the distance never underflows
    assign w_shamt = c_WIDTH_L - ld_len;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= ld_data << w_shamt;
        end else if (shift) begin
            r_sr <= {r_sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = r_sr[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : sequence_generator
// Description : Serial pattern transmitter, MSB-first, programmable length.
//               SEQ_GEN_REPEAT_EN enables back-to-back pattern repetition.
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_generator
    import seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    sequence_generator_if.slave bus
);
    localparam logic [LEN_W-1:0] c_WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] c_ONE     = LEN_W'(1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_len_eff;
    logic             w_load;
    logic             w_shift;
    logic             w_reload;
    logic [WIDTH-1:0] w_ld_data;
    logic [LEN_W-1:0] w_ld_len;
    logic             w_msb;

    assign w_len_eff = (bus.len > c_WIDTH_L) ? c_WIDTH_L : bus.len;

`ifdef SEQ_GEN_REPEAT_EN
    // the shift register consumes the pattern, so keep a copy for reloads
    logic [WIDTH-1:0] r_pat;
    logic [LEN_W-1:0] r_len;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pat <= '0;
            r_len <= '0;
        end else if (w_load) begin
            r_pat <= bus.data;
            r_len <= w_len_eff;
        end
    end

    assign w_ld_data = w_reload ? r_pat : bus.data;
    assign w_ld_len  = w_reload ? r_len : w_len_eff;
`else
    assign w_ld_data = bus.data;
    assign w_ld_len  = w_len_eff;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load || w_reload) begin
                r_cnt <= w_ld_len;
            end else if (w_shift) begin
                r_cnt <= r_cnt - c_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_reload    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && (bus.len != '0)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == c_ONE) begin
`ifdef SEQ_GEN_REPEAT_EN
                    if (bus.repeat_en) begin
                        w_reload = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    seq_shift_reg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shift_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load || w_reload),
        .shift   (w_shift),
        .ld_data (w_ld_data),
        .ld_len  (w_ld_len),
        .msb     (w_msb)
    );

    // all outputs decode registered state only
    assign bus.out_valid = (r_state == ST_SHIFT);
    assign bus.out       = w_msb && (r_state == ST_SHIFT);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter that drives bit streams into the sequence detector and similar serial-input blocks. A parallel pattern of programmable length is captured on a start request and shifted out MSB-first, one bit per clock, with a valid strobe. Busy and done indicators support back-to-back frames. The block is the stimulus-side counterpart of the detector and sits directly on its serial `in` port.

## Interface
- `WIDTH`, default 32: maximum pattern length in bits.
- `LEN_W`, default 6: width of `len`; must hold the value `WIDTH`.
- `clk`  input  1: single clock; all logic on its rising edge.
- `reset`  input  1: synchronous, active-low reset (the only clock and the only reset in the block).
- `start`  input  1: frame request, sampled each cycle.
- `data`  input  WIDTH: pattern; the active field is `data[len-1:0]`.
- `len`  input  LEN_W: number of bits to send.
- `out`  output  1: serial bit.
- `out_valid`  output  1: `out` carries a pattern bit this cycle.
- `busy`  output  1: frame in progress (states SHIFT or DONE).
- `done`  output  1: one-cycle end-of-frame pulse.
- `state`  output  2: current FSM state (IDLE=0, SHIFT=1, DONE=2).
- `repeat_en`  input  1: present only with `SEQ_GEN_REPEAT_EN`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `start`=1 with `len`≥1 captures `data` and the effective length, then moves to SHIFT.
  - SHIFT: emits one bit per cycle, starting at `data[len-1]` and ending at `data[0]`; moves to DONE after the last bit.
  - DONE: lasts one cycle; `done`=1, `out_valid`=0; then returns to IDLE.
- Effective length: `len`=0 means the start is ignored and the block stays in IDLE. `len`>WIDTH is clamped to WIDTH.
- Internal bit counter loads the effective length and decrements once per SHIFT cycle. The last bit is sent when the counter equals 1.
- `start` is ignored in SHIFT and DONE. `data` and `len` are don't-care except in the cycle a start is accepted.
- `out` is 0 whenever `out_valid`=0.
- Reset (`reset`=0 at an edge), including mid-frame:
  - After that edge: state IDLE; `out`, `out_valid`, `busy`, `done` all 0; shift register and counter cleared.
  - No `done` is issued for an aborted frame.
  - `start` is ignored while `reset`=0.

## Timing
- Start accepted at edge k: first bit valid in the cycle after edge k, with `out_valid`=1 and `busy`=1.
- Bits occupy cycles k+1 … k+L, where L is the effective length. `done`=1 in cycle k+L+1, and state is IDLE from cycle k+L+2.
- `busy` is high for L+1 cycles per frame.
- A new start may be sampled in the first IDLE cycle, so the minimum frame-to-frame gap is one DONE cycle plus one IDLE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SEQ_GEN_REPEAT_EN` defined: adds the `repeat_en` input.
  - `repeat_en` is sampled in the cycle of the last bit. If it is 1, the captured pattern reloads and bit L-1 follows the last bit with no gap; there is no DONE cycle and no `done` pulse.
  - Repetition continues until `repeat_en`=0 at a last-bit cycle; the frame then ends normally with DONE.
- `SEQ_GEN_REPEAT_EN` undefined: no `repeat_en` port; every frame is single-shot as described above.

## Structure
- Package `seq_pkg`: state encoding constants (`SEQ_IDLE`, `SEQ_SHIFT`, `SEQ_DONE`) and the 2-bit state typedef, shared with the detector bench.
- Sub-module `seq_shift_reg`: WIDTH-bit left-aligning load/shift register.
  - Loads `data` shifted so that bit `len-1` lands at the MSB.
  - Shifts left on enable; the serial output is the MSB.
- FSM, counter and clamping logic stay in `sequence_generator`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles → `out`=0, `out_valid`=0, `busy`=0, `done`=0, `state`=0.
- Basic frame: `data`=8'b10101100, `len`=8, start pulse → `out`=1,0,1,0,1,1,0,0 in 8 consecutive cycles with `out_valid`=1, then `done`=1 for 1 cycle; `busy` high for 9 cycles.
- Length edges:
  - `len`=0 → no state change.
  - `len`=40 with `data`=32'h8000_0001 → 32 bits sent, first 1, last 1.
  - `len`=1 with `data[0]`=1 → single bit 1, then `done`.
- Start during busy: second start pulse in the 3rd bit cycle → ignored, frame unchanged. Start held through DONE → next frame begins in the first IDLE cycle.
- Mid-frame reset: `reset`=0 after 3 bits of an 8-bit frame → IDLE next cycle, all outputs 0, no `done`.
- Repeat (macro defined): `len`=4, `data`=4'b1011, `repeat_en`=1 → 1,0,1,1,1,0,1,1 contiguous. `repeat_en`=0 before the second last bit → stream stops after 8 bits, then `done`=1.
